// File: rtl/vga_window_mapper.sv
// vga_window_mapper: maps 640x480 raster coordinates onto a WIN_W x WIN_H
// framebuffer window, issues the RAM read address, and re-aligns the RAM
// data with an in-window flag. Window can be scaled 1x/2x and slid
// horizontally with two debounced buttons; changes commit at frame start.

// Per-button conditioner: two-flop sync, stability counter, rising-edge pulse.
module vga_btn_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    sync;
    logic          lvl_q;
    logic          deb;
    logic          deb_q;
    logic [CW-1:0] cnt;

    // Synchronise, restart the counter on any level change, accept once stable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync  <= '0;
            lvl_q <= 1'b0;
            deb   <= 1'b0;
            deb_q <= 1'b0;
            cnt   <= '0;
        end else begin
            sync  <= {sync[0], btn};
            lvl_q <= sync[1];
            deb_q <= deb;
            if (sync[1] != lvl_q)
                cnt <= '0;
            else if (cnt == CW'(DEB_CYCLES - 1))
                deb <= lvl_q;
            else
                cnt <= cnt + 1'b1;
        end
    end

    // One pulse per accepted press, however long the button is held.
    assign pulse = deb & ~deb_q;
endmodule

module vga_window_mapper #(
    parameter int              SCREEN_W   = 640,
    parameter int              SCREEN_H   = 480,
    parameter int              WIN_W      = 256,
    parameter int              WIN_H      = 256,
    parameter int              AW         = 16,
    parameter int              DW         = 3,
    parameter int              OFF_Y      = 0,
    parameter int              STEP_X     = 16,
    parameter int              DEB_CYCLES = 16,
    parameter logic [DW-1:0]   BG_COLOR   = 3'b000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    posX,
    input  logic [8:0]    posY,
    input  logic          bntr,
    input  logic          bntl,
    input  logic          scale2x,
    input  logic [DW-1:0] mem_data,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] pixel_out,
    output logic          in_window,
    output logic [9:0]    off_x
);
    localparam int XB = $clog2(WIN_W);

    // press[0] = right, press[1] = left
    logic [1:0] btn_in;
    logic [1:0] press;
    assign btn_in = {bntl, bntr};

    for (genvar i = 0; i < 2; i++) begin : g_btn
        vga_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .rst   (rst),
            .btn   (btn_in[i]),
            .pulse (press[i])
        );
    end

    logic          scale_q;
    logic [9:0]    pend;
    logic [2:1]    vld_pipe;

    logic [10:0]   ew, eh, x11, xlo, y11;
    logic          in_x, in_y, win;
    logic [9:0]    xr;
    logic [8:0]    yr;
    logic [AW-1:0] addr_c;
    logic          frame_start;

    // Window test and framebuffer address from the committed offset/scale.
    always_comb begin
        ew     = 11'(WIN_W) << scale_q;
        eh     = 11'(WIN_H) << scale_q;
        x11    = {1'b0, posX};
        xlo    = {1'b0, off_x};
        y11    = {2'b0, posY};
        in_x   = (x11 >= xlo) && (x11 < xlo + ew);
        in_y   = (y11 >= 11'(OFF_Y)) && (y11 < 11'(OFF_Y) + eh) && (y11 < 11'(SCREEN_H));
        win    = in_x && in_y;
        xr     = posX - off_x;
        yr     = posY - 9'(OFF_Y);
        addr_c = '0;
        if (win)
            addr_c = AW'((32'(yr >> scale_q) << XB) | 32'(xr >> scale_q));
    end

    logic [9:0]  ew_in, lim, pend_nxt;
    logic [10:0] step_sum;

    assign frame_start = (posX == 10'd0) && (posY == 9'd0);

    // Pending offset: apply button pulses, clamp to the limit of the requested scale.
    always_comb begin
        ew_in    = 10'(WIN_W) << scale2x;
        lim      = 10'(SCREEN_W) - ew_in;
        step_sum = {1'b0, pend} + 11'(STEP_X);
        pend_nxt = pend;
        if (press[0] && !press[1])
            pend_nxt = (step_sum > {1'b0, lim}) ? lim : step_sum[9:0];
        else if (press[1] && !press[0])
            pend_nxt = (pend >= 10'(STEP_X)) ? pend - 10'(STEP_X) : '0;
        if (frame_start && (pend_nxt > lim))
            pend_nxt = lim;
    end

    // Offset/scale registers; off_x and scale move only on the frame-start pixel.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend    <= '0;
            off_x   <= '0;
            scale_q <= 1'b0;
        end else begin
            pend <= pend_nxt;
            if (frame_start) begin
                off_x   <= pend_nxt;
                scale_q <= scale2x;
            end
        end
    end

    // Three-stage pixel pipeline: address, RAM read, colour select.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_addr  <= '0;
            vld_pipe  <= '0;
            pixel_out <= '0;
            in_window <= 1'b0;
        end else begin
            mem_addr    <= addr_c;
            vld_pipe[1] <= win;
            vld_pipe[2] <= vld_pipe[1];
            pixel_out   <= vld_pipe[2] ? mem_data : BG_COLOR;
            in_window   <= vld_pipe[2];
        end
    end
endmodule

// File: tb/tb_vga_window_mapper.sv
// Bench for vga_window_mapper: random raster traffic against a behavioural
// model, button press sequences, scale changes and a mid-frame reset.
module tb_vga_window_mapper;
    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  posX;
    logic [8:0]  posY;
    logic        bntr, bntl, scale2x;
    logic [2:0]  mem_data = 3'b000;
    logic [15:0] mem_addr;
    logic [2:0]  pixel_out;
    logic        in_window;
    logic [9:0]  off_x;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // model state: committed offset/scale and pending offset
    int m_off = 0, m_s = 0, m_pend = 0;

    // expected pipeline contents
    logic [15:0] e_a1 = '0, e_a2 = '0;
    logic        e_f1 = 1'b0, e_f2 = 1'b0, e_inw = 1'b0;
    logic [2:0]  e_pix = '0;

    int          mx, my, mew;
    logic        minw;
    logic [15:0] maddr;

    vga_window_mapper #(
        .SCREEN_W(640), .SCREEN_H(480), .WIN_W(256), .WIN_H(256), .AW(16), .DW(3),
        .OFF_Y(0), .STEP_X(16), .DEB_CYCLES(16), .BG_COLOR(3'b000)
    ) dut (
        .clk(clk), .rst(rst), .posX(posX), .posY(posY), .bntr(bntr), .bntl(bntl),
        .scale2x(scale2x), .mem_data(mem_data), .mem_addr(mem_addr),
        .pixel_out(pixel_out), .in_window(in_window), .off_x(off_x)
    );

    always #20 clk = ~clk;

    function automatic logic [2:0] ram_fn(input logic [15:0] a);
        return a[2:0] ^ a[5:3] ^ a[8:6];
    endfunction

    // synchronous RAM, one cycle read latency
    always @(posedge clk) mem_data <= ram_fn(mem_addr);

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // behavioural model of the window mapping and its 3-cycle latency
    always @(posedge clk) begin
        if (!rst) begin
            e_a1 <= '0; e_a2 <= '0; e_f1 <= 1'b0; e_f2 <= 1'b0;
            e_pix <= '0; e_inw <= 1'b0;
        end else begin
            mx    = int'(posX);
            my    = int'(posY);
            mew   = 256 << m_s;
            minw  = (mx >= m_off) && (mx < m_off + mew) && (my < mew);
            maddr = minw ? 16'(((my >> m_s) * 256) + ((mx - m_off) >> m_s)) : 16'd0;
            e_a1  <= maddr;
            e_f1  <= minw;
            e_a2  <= e_a1;
            e_f2  <= e_f1;
            e_pix <= e_f2 ? ram_fn(e_a2) : 3'b000;
            e_inw <= e_f2;
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_addr", int'(mem_addr), int'(e_a1));
            chk("pixel_out", int'(pixel_out), int'(e_pix));
            chk("in_window", int'(in_window), int'(e_inw));
            chk("off_x", int'(off_x), m_off);
        end
    end

    task automatic tick(input int x, input int y);
        @(negedge clk);
        posX = 10'(x);
        posY = 9'(y);
    endtask

    task automatic trand();
        int x, y;
        x = $urandom_range(0, 639);
        y = $urandom_range(0, 479);
        if (x == 0 && y == 0) x = 1;
        tick(x, y);
    endtask

    task automatic press(input bit r, input bit l, input int hi);
        int lim;
        bntr = r; bntl = l;
        repeat (hi) trand();
        bntr = 1'b0; bntl = 1'b0;
        repeat (40) trand();
        if (hi >= 20) begin
            lim = 640 - (256 << scale2x);
            if (r && !l) m_pend = (m_pend + 16 > lim) ? lim : m_pend + 16;
            else if (l && !r) m_pend = (m_pend >= 16) ? m_pend - 16 : 0;
        end
    endtask

    task automatic commit();
        int lim;
        tick(0, 0);
        @(posedge clk);
        #1;
        lim = 640 - (256 << scale2x);
        if (m_pend > lim) m_pend = lim;
        m_off = m_pend;
        m_s   = int'(scale2x);
    endtask

    initial begin
        rst = 1'b0; posX = 10'd1; posY = 9'd1;
        bntr = 1'b0; bntl = 1'b0; scale2x = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset mem_addr", int'(mem_addr), 0);
        chk("reset pixel_out", int'(pixel_out), 0);
        chk("reset in_window", int'(in_window), 0);
        chk("reset off_x", int'(off_x), 0);
        rst = 1'b1;
        chk_en = 1'b1;

        // basic in-window pixel
        tick(5, 2); trand();
        chk("addr(5,2)", int'(mem_addr), 517);
        trand(); trand();
        chk("pix(5,2)", int'(pixel_out), 5);
        chk("inw(5,2)", int'(in_window), 1);

        // outside the window
        tick(300, 10); trand();
        chk("addr(300,10)", int'(mem_addr), 0);
        trand(); trand();
        chk("pix(300,10)", int'(pixel_out), 0);
        chk("inw(300,10)", int'(in_window), 0);

        repeat (200) trand();

        // single press held 40 cycles, committed only at frame start
        press(1, 0, 40);
        chk("off before commit", int'(off_x), 0);
        commit(); trand();
        chk("off one press", int'(off_x), 16);

        // glitch shorter than the debounce window
        press(1, 0, 10);
        commit(); trand();
        chk("off after glitch", int'(off_x), 16);

        // saturate right, then back to zero
        repeat (30) press(1, 0, 40);
        commit(); trand();
        chk("off sat right", int'(off_x), 384);
        repeat (30) press(0, 1, 40);
        commit(); trand();
        chk("off sat left", int'(off_x), 0);

        // simultaneous left+right does nothing
        press(1, 0, 40); press(1, 0, 40); press(1, 1, 40);
        commit(); trand();
        chk("off both buttons", int'(off_x), 32);

        // 2x scale clamps the offset
        repeat (30) press(1, 0, 40);
        commit(); trand();
        chk("off 384 again", int'(off_x), 384);
        scale2x = 1'b1;
        commit(); trand();
        chk("off clamp 2x", int'(off_x), 128);
        tick(130, 3); trand();
        chk("addr 2x(130,3)", int'(mem_addr), 257);
        tick(639, 3); tick(127, 3); trand(); trand();
        chk("inw 2x x=639", int'(in_window), 1);
        trand();
        chk("inw 2x x=127", int'(in_window), 0);
        repeat (200) trand();

        // random scale / offset mixes
        for (int k = 0; k < 6; k++) begin
            scale2x = 1'($urandom_range(0, 1));
            for (int j = 0; j < 3; j++)
                press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 40);
            commit();
            repeat (150) trand();
        end

        // mid-frame reset with a full pipeline
        scale2x = 1'b0;
        repeat (10) trand();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        m_off = 0; m_s = 0; m_pend = 0;
        @(negedge clk);
        chk("midrst mem_addr", int'(mem_addr), 0);
        chk("midrst pixel_out", int'(pixel_out), 0);
        chk("midrst in_window", int'(in_window), 0);
        chk("midrst off_x", int'(off_x), 0);
        rst = 1'b1;
        posX = 10'd5; posY = 9'd2;
        trand();
        chk("post-rst addr", int'(mem_addr), 517);
        trand(); trand();
        chk("post-rst pix", int'(pixel_out), 5);
        chk("post-rst inw", int'(in_window), 1);
        repeat (50) trand();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_window_mapper.md
Name: vga_window_mapper

Overview:
- Maps VGA raster coordinates from the 640x480 driver onto a WIN_W x WIN_H framebuffer held in the dual-port RAM.
- Generates a registered read address for the RAM.
- Aligns the RAM read data with an in-window flag and substitutes a border colour outside the window.
- Adds runtime 1x/2x pixel scaling and a horizontal window offset, moved by the debounced bntr/bntl buttons and committed only at frame start.

Parameters:
- SCREEN_W, 640, visible raster width
- SCREEN_H, 480, visible raster height
- WIN_W, 256, framebuffer width in pixels; must be a power of 2
- WIN_H, 256, framebuffer height in pixels
- AW, 16, RAM address width; must be at least log2(WIN_W*WIN_H)
- DW, 3, pixel width (RGB 111)
- OFF_Y, 0, fixed vertical window offset in raster lines
- STEP_X, 16, offset change per button press in pixels
- DEB_CYCLES, 16, number of cycles an input must be stable to be accepted
- BG_COLOR, 3'b000, colour output outside the window

Ports:
- clk  input  1  pixel clock (25 MHz); all logic on the rising edge
- rst  input  1  synchronous reset, active-low
- posX  input  10  raster X of the next pixel, from the VGA driver
- posY  input  9  raster Y of the next pixel, from the VGA driver
- bntr  input  1  move-right button, asynchronous, active-high
- bntl  input  1  move-left button, asynchronous, active-high
- scale2x  input  1  0 = 1x, 1 = 2x pixel replication
- mem_data  input  DW  RAM read data (synchronous RAM, 1-cycle read latency)
- mem_addr  output  AW  RAM read address
- pixel_out  output  DW  colour to the VGA driver pixelIn
- in_window  output  1  high when pixel_out is framebuffer data; aligned with pixel_out
- off_x  output  10  committed horizontal offset

Behaviour:
- Reset (rst=0 at a clock edge):
  - mem_addr=0, pixel_out=0, in_window=0, off_x=0.
  - Pending offset=0, committed scale=0.
  - Synchronisers, debounce counters and pipeline flags are cleared.
  - Applies mid-frame; normal operation resumes the cycle after rst returns to 1.
- Scale handling:
  - s = committed scale (0 or 1).
  - Effective window size: EW = WIN_W<<s, EH = WIN_H<<s.
- Window test (combinational on posX/posY):
  - posX >= off_x and posX < off_x+EW, and posY >= OFF_Y and posY < OFF_Y+EH.
  - The part below SCREEN_H is simply never reached.
- Address:
  - Relative coordinates: xr = posX-off_x, yr = posY-OFF_Y.
  - Inside the window: addr = ((yr>>s)*WIN_W) + (xr>>s), computed as a shift since WIN_W is a power of 2, truncated to AW.
  - Outside the window: addr=0.
- Pipeline:
  - Stage 1: mem_addr registered 1 cycle after posX/posY; the window flag is registered alongside it.
  - Stage 2: the RAM returns mem_data; the flag is delayed one more cycle.
  - Stage 3: pixel_out = flag ? mem_data : BG_COLOR, registered; in_window = flag.
  - Total latency from posX/posY to pixel_out is 3 cycles; throughput is one pixel per cycle.
- Buttons (each independently):
  - Two-flop synchroniser feeds a counter that resets on any change of the synchronised level.
  - The debounced level updates when the counter reaches DEB_CYCLES-1.
  - A rising edge of the debounced level produces a single-cycle press pulse; holding the button gives exactly one pulse.
- Pending offset, updated per pulse:
  - Right pulse: pend = min(pend+STEP_X, SCREEN_W-EW_pend), where EW_pend uses the scale2x input.
  - Left pulse: pend = max(pend-STEP_X, 0), computed without underflow.
  - Right and left pulses in the same cycle: no change.
  - Several pulses in one frame accumulate.
- Frame-start commit (posX==0 and posY==0, one cycle):
  - off_x <= pend and s <= scale2x.
  - If pend > SCREEN_W-(WIN_W<<scale2x), both off_x and pend are clamped to that value.
  - off_x and s never change at any other time, so there is no tearing.
- A button pulse coinciding with the commit cycle is included in the value committed.

Test Plan:
- After reset, scale2x=0: drive posX=5, posY=2 → mem_addr=517 one cycle later. Drive mem_data=3'b110 on the following cycle → pixel_out=3'b110, in_window=1 three cycles after the posX/posY input.
- posX=300, posY=10, off_x=0 → mem_addr=0; three cycles later pixel_out=BG_COLOR, in_window=0.
- bntr high for 40 cycles with DEB_CYCLES=16 → exactly one pulse. off_x stays 0 until the posX=0, posY=0 cycle, then off_x=16. A bntr glitch shorter than 16 cycles → no change.
- 30 bntr presses → off_x saturates at 384. Then 30 bntl presses → off_x=0, no wrap. bntr and bntl pulsing in the same cycle → pend unchanged.
- off_x=384, then set scale2x=1 → at frame start off_x clamps to 128, s=1. Then posX=130, posY=3 → mem_addr=257. posX=640-1 → in window; posX=127 → out of window.
- Assert rst=0 mid-frame while the pipeline is full → the next cycle has all outputs 0 and off_x=0. Release → the first valid pixel_out appears 3 cycles after the first posX/posY presented.
